keyboard_decoder: RTL

Receives the PS/2 keyboard serial stream, decodes scan-code set 2 make/break sequences and presents the currently held movement key as a 4-bit code. It sits directly upstream of the player movement controller, driving its `key[3:0]` input. The output is a clean, registered value in the system clock domain that changes only on complete, error-free scan-code sequences.

---
 rtl/keyboard_decoder.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/keyboard_decoder.sv
// keyboard_decoder: PS/2 scan-code set 2 receiver that tracks the currently
// held movement key and presents it as a registered 4-bit code.
//
// Optional feature macro: KEY_EXT_ARROWS_EN
//   defined   - E0-prefixed arrow keys alias onto A/D/W/S
//   undefined - extended make/break codes are consumed and ignored
//
// Handshake note: byte_valid is a single-cycle qualifier with no back-pressure;
// the sequence FSM must accept a byte in every cycle byte_valid is high.
// key_strobe and frame_err are single-cycle event pulses with no ready.
module keyboard_decoder #(
    parameter int TIMEOUT_CYC = 65_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [3:0] key,
    output logic       key_strobe,
    output logic       frame_err,
    output logic [1:0] frame_state_dbg,
    output logic [1:0] seq_state_dbg
);

    localparam int WDOG_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [3:0] KEY_NONE  = 4'h0;
    localparam logic [3:0] KEY_A     = 4'h1;
    localparam logic [3:0] KEY_D     = 4'h2;
    localparam logic [3:0] KEY_W     = 4'h3;
    localparam logic [3:0] KEY_S     = 4'h4;
    localparam logic [3:0] KEY_SPACE = 4'h5;

    localparam logic [7:0] CODE_BREAK = 8'hF0;
    localparam logic [7:0] CODE_EXT   = 8'hE0;

    typedef enum logic [1:0] {
        WAIT_START = 2'd0,
        SHIFT      = 2'd1,
        PARITY     = 2'd2,
        STOP       = 2'd3
    } frame_state_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BRK    = 2'd1,
        S_EXT    = 2'd2,
        S_EXTBRK = 2'd3
    } seq_state_t;

    // Input conditioning signals
    logic ps2_clk_s1, ps2_clk_s2, ps2_clk_prev;
    logic ps2_data_s1, ps2_data_s2, data_d;
    logic fall;

    // Frame receiver signals
    frame_state_t      fstate;
    logic [2:0]        bit_cnt;
    logic [7:0]        shreg;
    logic              par_bit;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic [WDOG_W-1:0] wdog;

    // Sequence decoder signals
    seq_state_t sstate;
    logic [3:0] code;
    logic       is_break;
    logic       is_prefix;

    assign frame_state_dbg = fstate;
    assign seq_state_dbg   = sstate;

    // Translate a scan code into a key code; 0 means the code is not a movement key.
    function automatic logic [3:0] map_code(input logic [7:0] b, input logic ext);
        logic [3:0] k;
        k = KEY_NONE;
        if (!ext) begin
            case (b)
                8'h1C:   k = KEY_A;
                8'h23:   k = KEY_D;
                8'h1D:   k = KEY_W;
                8'h1B:   k = KEY_S;
                8'h29:   k = KEY_SPACE;
                default: k = KEY_NONE;
            endcase
        end else begin
`ifdef KEY_EXT_ARROWS_EN
            case (b)
                8'h6B:   k = KEY_A;
                8'h74:   k = KEY_D;
                8'h75:   k = KEY_W;
                8'h72:   k = KEY_S;
                default: k = KEY_NONE;
            endcase
`else
            k = KEY_NONE;
`endif
        end
        return k;
    endfunction

    // Synchronise both PS/2 lines and register a falling-edge pulse on the clock line;
    // data is delayed alongside so it lines up with fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            ps2_clk_s1   <= 1'b1;
            ps2_clk_s2   <= 1'b1;
            ps2_clk_prev <= 1'b1;
            ps2_data_s1  <= 1'b1;
            ps2_data_s2  <= 1'b1;
            data_d       <= 1'b1;
            fall         <= 1'b0;
        end else begin
            ps2_clk_s1   <= ps2_clk;
            ps2_clk_s2   <= ps2_clk_s1;
            ps2_clk_prev <= ps2_clk_s2;
            ps2_data_s1  <= ps2_data;
            ps2_data_s2  <= ps2_data_s1;
            data_d       <= ps2_data_s2;
            fall         <= ps2_clk_prev & ~ps2_clk_s2;
        end
    end

    // Frame FSM: start bit, 8 data bits LSB first, odd parity, stop bit, plus watchdog.
    always_ff @(posedge clk) begin
        if (rst) begin
            fstate     <= WAIT_START;
            bit_cnt    <= 3'd0;
            shreg      <= 8'h00;
            par_bit    <= 1'b0;
            byte_valid <= 1'b0;
            byte_data  <= 8'h00;
            frame_err  <= 1'b0;
            wdog       <= '0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;

            if (fall) begin
                wdog <= '0;
            end else if (fstate != WAIT_START) begin
                wdog <= wdog + 1'b1;
            end

            if (fstate != WAIT_START && !fall && wdog == WDOG_W'(TIMEOUT_CYC)) begin
                // Keyboard went quiet mid-frame: drop the partial byte.
                fstate    <= WAIT_START;
                frame_err <= 1'b1;
                wdog      <= '0;
            end else if (fall) begin
                case (fstate)
                    WAIT_START: begin
                        if (!data_d) begin
                            fstate  <= SHIFT;
                            bit_cnt <= 3'd0;
                        end
                    end
                    SHIFT: begin
                        shreg   <= {data_d, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            fstate <= PARITY;
                        end
                    end
                    PARITY: begin
                        par_bit <= data_d;
                        fstate  <= STOP;
                    end
                    STOP: begin
                        if ((^{shreg, par_bit}) && data_d) begin
                            byte_valid <= 1'b1;
                            byte_data  <= shreg;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        fstate <= WAIT_START;
                    end
                    default: fstate <= WAIT_START;
                endcase
            end
        end
    end

    // Classify the received byte in the context of any pending F0/E0 prefix.
    always_comb begin
        code      = map_code(byte_data, (sstate == S_EXT) || (sstate == S_EXTBRK));
        is_break  = (sstate == S_BRK) || (sstate == S_EXTBRK);
        is_prefix = ((sstate == S_IDLE) && (byte_data == CODE_BREAK || byte_data == CODE_EXT)) ||
                    ((sstate == S_EXT)  && (byte_data == CODE_BREAK));
    end

    // Sequence FSM and held-key register; strobe only when key really changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            sstate     <= S_IDLE;
            key        <= KEY_NONE;
            key_strobe <= 1'b0;
        end else begin
            key_strobe <= 1'b0;
            if (byte_valid) begin
                case (sstate)
                    S_IDLE: begin
                        if (byte_data == CODE_BREAK) begin
                            sstate <= S_BRK;
                        end else if (byte_data == CODE_EXT) begin
                            sstate <= S_EXT;
                        end
                    end
                    S_EXT: begin
                        if (byte_data == CODE_BREAK) begin
                            sstate <= S_EXTBRK;
                        end else begin
                            sstate <= S_IDLE;
                        end
                    end
                    default: sstate <= S_IDLE;
                endcase

                if (!is_prefix && code != KEY_NONE) begin
                    if (!is_break && code != key) begin
                        key        <= code;
                        key_strobe <= 1'b1;
                    end else if (is_break && code == key) begin
                        key        <= KEY_NONE;
                        key_strobe <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
